// File: rtl/q_timed_event_queue.sv
// q_timed_event_queue
// Timed-release event queue. Each entry holds a release timestamp and a payload.
// When the time counter reaches the head entry's timestamp, that entry is popped
// and presented on the fire_* outputs one cycle later. This block sits between the
// instruction decoder and the pulse/measurement channel drivers.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, stop           run control (start wins over stop; start restarts time at 0)
//   wr_en, wr_ts, wr_data push request, release timestamp and payload
//   fire_valid            one-cycle pulse when an entry is released
//   fire_data, fire_late  released payload and late flag, valid with fire_valid
//   cur_time              free-running time counter (counts only while running)
//   count, full, empty    occupancy derived from the registered pointers
//   overflow              sticky: a push was attempted while full
//   running               FSM is in RUN
//   late_cnt              (TQ_LATE_DROP_EN only) saturating count of dropped late entries
//
// Build option: define TQ_LATE_DROP_EN to drop late entries instead of firing them.
//
// state | meaning
// IDLE  | time counter frozen, no releases
// RUN   | time counter increments every cycle, due head entries are released

module q_timed_event_queue #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 20,
  parameter int TS_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    wr_en,
  input  logic [TS_WIDTH-1:0]     wr_ts,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    fire_valid,
  output logic [DATA_WIDTH-1:0]   fire_data,
  output logic                    fire_late,
  output logic [TS_WIDTH-1:0]     cur_time,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    running
`ifdef TQ_LATE_DROP_EN
  ,
  output logic [15:0]             late_cnt
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [TS_WIDTH-1:0] TS_ONE  = 1;
  localparam logic [PW-1:0]       PTR_ONE = 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [TS_WIDTH-1:0] time_nxt;

  logic [TS_WIDTH-1:0]   ts_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [IW-1:0]       rd_idx, wr_idx;
  logic [TS_WIDTH-1:0] head_delta;
  logic                head_late;
  logic                due;
  logic                push, pop;
  logic                fire_nxt;

  // ---------------- FSM and time counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur_time <= '0;
    end else begin
      state    <= state_nxt;
      cur_time <= time_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    time_nxt  = cur_time;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          time_nxt  = '0;
        end
      end
      ST_RUN: begin
        if (start) begin
          time_nxt = '0;
        end else if (stop) begin
          state_nxt = ST_IDLE;
        end else begin
          time_nxt = cur_time + TS_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign running = (state == ST_RUN);

  // ---------------- occupancy ----------------
  assign rd_idx = rd_ptr[IW-1:0];
  assign wr_idx = wr_ptr[IW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign count  = wr_ptr - rd_ptr;

  // ---------------- due test ----------------
  // The difference is read as a signed value so the compare stays correct across
  // a wrap of the time counter, as long as timestamps stay within half the range.
  assign head_delta = ts_mem[rd_idx] - cur_time;
  assign head_late  = head_delta[TS_WIDTH-1];
  assign due        = running && !empty && (head_late || (head_delta == '0));

  assign push = wr_en && !full;
  assign pop  = due;

`ifdef TQ_LATE_DROP_EN
  assign fire_nxt = pop && !head_late;
`else
  assign fire_nxt = pop;
`endif

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[wr_idx]   <= wr_ts;
      data_mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      fire_valid <= 1'b0;
      fire_data  <= '0;
      fire_late  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      fire_valid <= fire_nxt;
      if (fire_nxt) begin
        fire_data <= data_mem[rd_idx];
        fire_late <= head_late;
      end
    end
  end

`ifdef TQ_LATE_DROP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      late_cnt <= '0;
    end else if (pop && head_late && (late_cnt != 16'hFFFF)) begin
      late_cnt <= late_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_q_timed_event_queue.sv
module tb_q_timed_event_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic        reset, start, stop, wr_en;
  logic [31:0] wr_ts;
  logic [19:0] wr_data;
  logic        fire_valid, fire_late, full, empty, overflow, running;
  logic [19:0] fire_data;
  logic [31:0] cur_time;
  logic [5:0]  count;

  // narrow-timestamp instance for the wrap test
  logic        reset8, start8, stop8, wr_en8;
  logic [7:0]  wr_ts8;
  logic [19:0] wr_data8;
  logic        fire_valid8, fire_late8, full8, empty8, overflow8, running8;
  logic [19:0] fire_data8;
  logic [7:0]  cur_time8;
  logic [2:0]  count8;

`ifdef TQ_LATE_DROP_EN
  logic [15:0] late_cnt, late_cnt8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  q_timed_event_queue dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_ts(wr_ts), .wr_data(wr_data),
    .fire_valid(fire_valid), .fire_data(fire_data), .fire_late(fire_late),
    .cur_time(cur_time), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .running(running)
`ifdef TQ_LATE_DROP_EN
    , .late_cnt(late_cnt)
`endif
  );

  q_timed_event_queue #(.DEPTH(4), .DATA_WIDTH(20), .TS_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .stop(stop8),
    .wr_en(wr_en8), .wr_ts(wr_ts8), .wr_data(wr_data8),
    .fire_valid(fire_valid8), .fire_data(fire_data8), .fire_late(fire_late8),
    .cur_time(cur_time8), .count(count8), .full(full8), .empty(empty8),
    .overflow(overflow8), .running(running8)
`ifdef TQ_LATE_DROP_EN
    , .late_cnt(late_cnt8)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_to(input logic [31:0] target);
    for (int i = 0; i < 400 && cur_time != target; i++) cyc();
  endtask

  task automatic wait_fire(input int maxc, output bit got, output logic [31:0] t,
                           output logic [19:0] d, output logic late);
    got = 0; t = '0; d = '0; late = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      cyc();
      if (fire_valid) begin
        got = 1; t = cur_time; d = fire_data; late = fire_late;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; reset8 = 1'b1;
    cyc(); cyc();
    reset = 1'b0; reset8 = 1'b0;
    n_checks++; if (fire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fire_valid: got %b expected 0", fire_valid); end
    n_checks++; if (fire_data !== 20'h0) begin n_fail++; $display("FAIL reset_fire_data: got %h expected 0", fire_data); end
    n_checks++; if (fire_late !== 1'b0) begin n_fail++; $display("FAIL reset_fire_late: got %b expected 0", fire_late); end
    n_checks++; if (cur_time !== 32'h0) begin n_fail++; $display("FAIL reset_cur_time: got %0d expected 0", cur_time); end
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    n_checks++; if (empty8 !== 1'b1) begin n_fail++; $display("FAIL reset_empty8: got %b expected 1", empty8); end
`ifdef TQ_LATE_DROP_EN
    n_checks++; if (late_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_late_cnt: got %0d expected 0", late_cnt); end
`endif
  endtask

  task automatic test_basic();
    bit got; logic [31:0] t; logic [19:0] d; logic late;
    do_reset();
    do_start();
    n_checks++; if (cur_time !== 32'd0 || running !== 1'b1) begin n_fail++; $display("FAIL basic_start: got time %0d run %b expected 0/1", cur_time, running); end
    cyc(); cyc();
    n_checks++; if (cur_time !== 32'd2) begin n_fail++; $display("FAIL basic_time: got %0d expected 2", cur_time); end
    wr_en = 1'b1; wr_ts = 32'd10; wr_data = 20'hA;
    cyc();
    wr_en = 1'b0;
    n_checks++; if (count !== 6'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL basic_count: got %0d empty %b expected 1/0", count, empty); end
    wait_fire(30, got, t, d, late);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL basic_fired: got %b expected 1", got); end
    n_checks++; if (t !== 32'd11) begin n_fail++; $display("FAIL basic_fire_time: got %0d expected 11", t); end
    n_checks++; if (d !== 20'hA) begin n_fail++; $display("FAIL basic_fire_data: got %h expected a", d); end
    n_checks++; if (late !== 1'b0) begin n_fail++; $display("FAIL basic_fire_late: got %b expected 0", late); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after: got %b expected 1", empty); end
    cyc();
    n_checks++; if (fire_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b expected 0", fire_valid); end
  endtask

  task automatic test_full_overflow();
    int idx;
    do_reset();
    do_start();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_ts = 32'd100 + 32'(i); wr_data = 20'h100 + 20'(i);
      cyc();
    end
    n_checks++; if (full !== 1'b1 || count !== 6'd32) begin n_fail++; $display("FAIL full_flag: got full %b count %0d expected 1/32", full, count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf_yet: got %b expected 0", overflow); end
    wr_ts = 32'd200; wr_data = 20'hFFFFF;
    cyc();
    wr_en = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b expected 1", overflow); end
    n_checks++; if (count !== 6'd32) begin n_fail++; $display("FAIL full_count_after_drop: got %0d expected 32", count); end
    idx = 0;
    for (int c = 0; c < 250; c++) begin
      cyc();
      if (fire_valid) begin
        n_checks++; if (fire_data !== 20'h100 + 20'(idx)) begin n_fail++; $display("FAIL full_order_data: got %h expected %h", fire_data, 20'h100 + 20'(idx)); end
        n_checks++; if (cur_time !== 32'd101 + 32'(idx)) begin n_fail++; $display("FAIL full_order_time: got %0d expected %0d", cur_time, 101 + idx); end
        idx++;
      end
    end
    n_checks++; if (idx !== 32) begin n_fail++; $display("FAIL full_fire_total: got %0d expected 32", idx); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_stop_restart();
    bit got; logic [31:0] t; logic [19:0] d; logic late;
    int bad;
    do_reset();
    do_start();
    cyc();
    wr_en = 1'b1; wr_ts = 32'd60; wr_data = 20'h60;
    cyc();
    wr_en = 1'b0;
    run_to(32'd50);
    n_checks++; if (cur_time !== 32'd50) begin n_fail++; $display("FAIL stop_reach: got %0d expected 50", cur_time); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++; if (running !== 1'b0 || cur_time !== 32'd50) begin n_fail++; $display("FAIL stop_idle: got run %b time %0d expected 0/50", running, cur_time); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (fire_valid !== 1'b0 || cur_time !== 32'd50) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stop_frozen: got %0d bad cycles expected 0", bad); end
    n_checks++; if (count !== 6'd1) begin n_fail++; $display("FAIL stop_count: got %0d expected 1", count); end
    do_start();
    n_checks++; if (running !== 1'b1 || cur_time !== 32'd0) begin n_fail++; $display("FAIL stop_restart: got run %b time %0d expected 1/0", running, cur_time); end
    wait_fire(100, got, t, d, late);
    n_checks++; if (got !== 1'b1 || t !== 32'd61) begin n_fail++; $display("FAIL stop_fire_time: got fired %b at %0d expected 1 at 61", got, t); end
    n_checks++; if (d !== 20'h60 || late !== 1'b0) begin n_fail++; $display("FAIL stop_fire_data: got %h late %b expected 60/0", d, late); end
    run_to(32'd5);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    n_checks++; if (running !== 1'b1 || cur_time !== 32'd0) begin n_fail++; $display("FAIL start_beats_stop: got run %b time %0d expected 1/0", running, cur_time); end
  endtask

  task automatic test_late();
    do_reset();
    do_start();
    run_to(32'd20);
    wr_en = 1'b1; wr_ts = 32'd5; wr_data = 20'h55;
    cyc();
    wr_en = 1'b0;
    n_checks++; if (fire_valid !== 1'b0) begin n_fail++; $display("FAIL late_early_fire: got %b expected 0", fire_valid); end
    cyc();
`ifdef TQ_LATE_DROP_EN
    n_checks++; if (fire_valid !== 1'b0) begin n_fail++; $display("FAIL late_dropped: got %b expected 0", fire_valid); end
    n_checks++; if (late_cnt !== 16'd1) begin n_fail++; $display("FAIL late_cnt: got %0d expected 1", late_cnt); end
`else
    n_checks++; if (fire_valid !== 1'b1) begin n_fail++; $display("FAIL late_fire: got %b expected 1", fire_valid); end
    n_checks++; if (fire_late !== 1'b1 || fire_data !== 20'h55) begin n_fail++; $display("FAIL late_flag: got late %b data %h expected 1/55", fire_late, fire_data); end
`endif
    cyc();
    n_checks++; if (fire_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL late_after: got fv %b empty %b expected 0/1", fire_valid, empty); end
  endtask

  task automatic test_wrap();
    bit got; logic [7:0] t; logic [19:0] d; logic late;
    reset8 = 1'b1; cyc(); reset8 = 1'b0;
    start8 = 1'b1; cyc(); start8 = 1'b0;
    for (int i = 0; i < 300 && cur_time8 != 8'd253; i++) cyc();
    n_checks++; if (cur_time8 !== 8'd253) begin n_fail++; $display("FAIL wrap_reach: got %0d expected 253", cur_time8); end
    wr_en8 = 1'b1; wr_ts8 = 8'd2; wr_data8 = 20'h2;
    cyc();
    wr_en8 = 1'b0;
    got = 0; t = '0; d = '0; late = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (fire_valid8) begin got = 1; t = cur_time8; d = fire_data8; late = fire_late8; end
    end
    n_checks++; if (got !== 1'b1 || t !== 8'd3) begin n_fail++; $display("FAIL wrap_fire_time: got fired %b at %0d expected 1 at 3", got, t); end
    n_checks++; if (late !== 1'b0 || d !== 20'h2) begin n_fail++; $display("FAIL wrap_fire_data: got late %b data %h expected 0/2", late, d); end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    do_start();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_ts = 32'd40 + 32'(i); wr_data = 20'h200 + 20'(i);
      cyc();
    end
    wr_en = 1'b0;
    run_to(32'd40);
    n_checks++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_precond: got full %b ovf %b expected 1/0", full, overflow); end
    wr_en = 1'b1; wr_ts = 32'd500; wr_data = 20'hBEEF;
    cyc();
    n_checks++; if (count !== 6'd31 || overflow !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL fpp_reject: got count %0d ovf %b full %b expected 31/1/0", count, overflow, full); end
    n_checks++; if (fire_valid !== 1'b1 || fire_data !== 20'h200) begin n_fail++; $display("FAIL fpp_pop: got fv %b data %h expected 1/200", fire_valid, fire_data); end
    wr_ts = 32'd600; wr_data = 20'hCAFE;
    cyc();
    wr_en = 1'b0;
    n_checks++; if (count !== 6'd31) begin n_fail++; $display("FAIL fpp_simul_count: got %0d expected 31", count); end
    n_checks++; if (fire_valid !== 1'b1 || fire_data !== 20'h201) begin n_fail++; $display("FAIL fpp_second_pop: got fv %b data %h expected 1/201", fire_valid, fire_data); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    do_start();
    cyc();
    wr_en = 1'b1; wr_ts = 32'd3; wr_data = 20'h33;
    cyc();
    wr_ts = 32'd4; wr_data = 20'h44;
    cyc();
    wr_en = 1'b0;
    n_checks++; if (cur_time !== 32'd3 || count !== 6'd2) begin n_fail++; $display("FAIL rmid_precond: got time %0d count %0d expected 3/2", cur_time, count); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_checks++; if (fire_valid !== 1'b0 || empty !== 1'b1 || count !== 6'd0) begin n_fail++; $display("FAIL rmid_cleared: got fv %b empty %b count %0d expected 0/1/0", fire_valid, empty, count); end
    n_checks++; if (running !== 1'b0 || cur_time !== 32'd0) begin n_fail++; $display("FAIL rmid_fsm: got run %b time %0d expected 0/0", running, cur_time); end
    do_start();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (fire_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_no_fire: got %0d fires expected 0", bad); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0; wr_ts = '0; wr_data = '0;
    reset8 = 1'b1; start8 = 1'b0; stop8 = 1'b0; wr_en8 = 1'b0; wr_ts8 = '0; wr_data8 = '0;
    test_reset();
    test_basic();
    test_full_overflow();
    test_stop_restart();
    test_late();
    test_wrap();
    test_full_pop_push();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
